// File: rtl/adder_pkg.sv
// Shared types and default sizing for the multi-word sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

  // Default slice width and number of slices per operand.
  localparam int BITS_DEF  = 4;
  localparam int WORDS_DEF = 4;

  // Controller states: waiting for a request, stepping through words, holding the answer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry.sv
// One BITS-wide ripple-carry adder slice: s + co*2^BITS = a + b + ci.
// Latency: combinational.
// Backpressure: none (pure logic).
module ripple_carry #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  output logic [BITS-1:0] s,
  output logic            co
);

  logic [BITS:0] c;

  // Full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BITS; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[BITS];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W-bit adder (W = BITS*WORDS) time-sharing one BITS-wide ripple slice, one word per cycle.
// Latency: out_valid WORDS+1 cycles after acceptance; one request in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready low from acceptance until the cycle after the output handshake.
// Optional: define MULTIWORD_ADD_SEQ_SUB_EN to add the 'sub' input (A - B, carry_out=1 means no borrow).
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS*WORDS-1:0] op_a,
  input  logic [BITS*WORDS-1:0] op_b,
  input  logic                  c_in,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS*WORDS-1:0] result,
  output logic                  carry_out
);

  localparam int W  = BITS * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [KW-1:0]   k;
  logic [W-1:0]    result_q;

  logic [BITS-1:0] slice_a;
  logic [BITS-1:0] slice_b;
  logic [BITS-1:0] slice_s;
  logic            slice_co;

  logic            accept;
  logic            last_word;

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    last_word = (k == K_LAST);
  end

  // Select the current word of each captured operand for the shared slice.
  always_comb begin
    slice_a = a_q[int'(k)*BITS +: BITS];
    slice_b = b_q[int'(k)*BITS +: BITS];
  end

  ripple_carry #(
    .BITS (BITS)
  ) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, step through every word, wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode: handshake flags follow the state directly.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on acceptance, then fold one word per RUN cycle into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k        <= '0;
      result_q <= '0;
    end else if (accept) begin
      a_q <= op_a;
      k   <= '0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      // Subtraction reuses the adder as A + ~B + 1; c_in is not used then.
      b_q     <= sub ? ~op_b : op_b;
      carry_q <= sub ? 1'b1 : c_in;
`else
      b_q     <= op_b;
      carry_q <= c_in;
`endif
    end else if (state == RUN) begin
      result_q[int'(k)*BITS +: BITS] <= slice_s;
      carry_q                        <= slice_co;
      // Index parks on the last word so it never wraps.
      if (!last_word) begin
        k <= k + 1'b1;
      end
    end
  end

  // After the last word the carry register holds the final carry out.
  always_comb begin
    result    = result_q;
    carry_out = carry_q;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter BITS, default 4, meaning the width of the shared ripple-carry adder slice (one word).
REQ-002 SHALL have parameter WORDS, default 4, meaning words per operand; operand width is W = BITS*WORDS; WORDS >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 is the rising-edge clock; rst_n input 1 is the asynchronous active-low reset.
REQ-004 in_valid input 1: the request operands are valid.
REQ-005 in_ready output 1: the block accepts a request this cycle.
REQ-006 op_a input W: operand A.
REQ-007 op_b input W: operand B.
REQ-008 c_in input 1: initial carry into word 0.
REQ-009 out_valid output 1: result and carry_out are valid.
REQ-010 out_ready input 1: the consumer accepts the result.
REQ-011 result output W: the sum.
REQ-012 carry_out output 1: the carry out of the most significant word.

Function
REQ-013 SHALL compute {carry_out, result} = op_a + op_b + c_in, modulo 2^(W+1), using exactly one BITS-wide adder instance, time-shared across words.
REQ-014 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 IDLE: in_ready=1; when in_valid&&in_ready, SHALL capture op_a, op_b and c_in into registers, clear word index k=0, and go to RUN.
REQ-016 RUN: each cycle SHALL add word k of A and B plus the carry register, write the sum into result bits [k*BITS +: BITS], and store the slice carry-out into the carry register.
REQ-017 RUN: k SHALL increment each cycle; after processing k=WORDS-1 the FSM SHALL go to DONE; latency from acceptance to out_valid is exactly WORDS+1 cycles.
REQ-018 DONE: out_valid=1, with result and carry_out held stable until out_valid&&out_ready, then the FSM SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; no request is accepted until the cycle after the handshake completes (no overlap).
REQ-020 out_ready asserted outside DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored and the request SHALL NOT be captured.
REQ-021 The captured operands SHALL NOT change while in RUN or DONE, regardless of input changes.
REQ-022 result SHALL change only during RUN; when out_valid=0, the values of result and carry_out carry no meaning.
REQ-023 The word index SHALL be $clog2(WORDS) bits wide and SHALL NOT wrap while in RUN.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously enter IDLE and clear in_ready=1, out_valid=0, result=0, carry_out=0, k=0 and the carry register.
REQ-025 A reset asserted mid-RUN or mid-DONE SHALL abort the operation and produce no out_valid pulse; the first request after reset release SHALL be accepted normally.

Configuration
REQ-026 When the macro MULTIWORD_ADD_SEQ_SUB_EN is defined, the block SHALL have an extra input sub (1 bit) sampled with the request; when sub=1 it SHALL compute op_a + ~op_b + 1 (ignoring c_in), and carry_out=1 SHALL mean no borrow.
REQ-027 When MULTIWORD_ADD_SEQ_SUB_EN is undefined, the sub port SHALL NOT exist and the behaviour SHALL be pure addition per REQ-013.

Structure
REQ-028 The package adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default BITS/WORDS constants.
REQ-029 The single adder slice SHALL be one ripple_carry instance with BITS=BITS; no other arithmetic on operand words SHALL be used.

Verification
REQ-030 BITS=4, WORDS=4: A=0x1234, B=0x1111, c_in=0 -> out_valid 5 cycles after acceptance, result=0x2345, carry_out=0.
REQ-031 A=0xFFFF, B=0x0000, c_in=1 -> result=0x0000, carry_out=1, with the carry propagating through all 4 words.
REQ-032 Back-pressure: out_ready=0 for 10 cycles in DONE -> result stays stable and in_ready stays 0; first out_ready=1 -> IDLE on the next cycle.
REQ-033 Operands changed and in_valid pulsed during RUN -> the result matches the originally captured operands and the second request is not accepted.
REQ-034 rst_n asserted at RUN k=2 -> outputs are at reset values immediately; the next request 0x00FF+0x0001 gives 0x0100.
REQ-035 With MULTIWORD_ADD_SEQ_SUB_EN: A=0x0005, B=0x0007, sub=1 -> result=0xFFFE, carry_out=0 (borrow).
